// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
//
// Control unit for a multi-cycle MIPS datapath that shares one memory for
// instructions and data. A registered state machine walks every instruction
// through fetch, decode, execute, memory and writeback. It drives all datapath
// strobes and the ALU control code from the current state.
//
// Supported: R-type AND/OR/ADD/SUB/SLT, lw, sw, beq, bne, addi, j.
// Unsupported encodings park the machine in TRAP until reset.
//
// Parameters
//   ALU_CTRL_W  : alu_control width (>= 4). Bits above [3:0] are driven 0.
//   MEM_WAIT_EN : 1 = memory states wait for mem_ready.
//                 0 = mem_ready is ignored and memory states take one cycle.
//   CNT_W       : width of the retired-instruction counter.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   opcode/funct : IR[31:26] / IR[5:0]; stable from DECODE to next FETCH
//   zero         : ALU zero flag, used in BRANCH
//   mem_ready    : memory completed the current access
//   pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
//   reg_dst, reg_write, alu_src_a, alu_src_b, alu_control : datapath controls
//   state        : current state encoding (debug)
//   illegal      : high while in TRAP
//   instr_count  : retired instruction count, wraps modulo 2^CNT_W
// ============================================================================
module multicycle_control #(
    parameter int ALU_CTRL_W  = 4,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  ir_write,
    output logic                  i_or_d,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  reg_dst,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    function automatic logic funct_is_legal(input logic [5:0] f);
        case (f)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
        case (f)
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    state_t     cur_state;
    state_t     nxt_state;
    logic       is_store;   // lw/sw flavour, captured in DECODE
    logic       is_bne;     // beq/bne flavour, captured in DECODE
    logic       ready_eff;
    logic       retire;
    logic [3:0] alu_code;

    // With waiting disabled every memory access is treated as complete.
    assign ready_eff = MEM_WAIT_EN ? mem_ready : 1'b1;

    // ------------------------------------------------------------------
    // State register, decode flavour flags and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_FETCH;
            is_store    <= 1'b0;
            is_bne      <= 1'b0;
            instr_count <= '0;
        end else begin
            cur_state <= nxt_state;
            // opcode is only looked at in DECODE; later states use these flags.
            if (cur_state == S_DECODE) begin
                is_store <= (opcode == OP_SW);
                is_bne   <= (opcode == OP_BNE);
            end
            if (retire) begin
                instr_count <= instr_count + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and retire strobe
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = cur_state;
        retire    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                if (ready_eff) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt_state = funct_is_legal(funct) ? S_R_EXEC : S_TRAP;
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_I_EXEC;
                    OP_J:         nxt_state = S_JUMP;
                    default:      nxt_state = S_TRAP;
                endcase
            end
            S_MEM_ADDR: nxt_state = is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (ready_eff) nxt_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_MEM_WR: begin
                if (ready_eff) begin
                    nxt_state = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_R_EXEC: nxt_state = S_R_WB;
            S_R_WB, S_BRANCH, S_I_WB, S_JUMP: begin
                nxt_state = S_FETCH;
                retire    = 1'b1;
            end
            S_I_EXEC: nxt_state = S_I_WB;
            S_TRAP:   nxt_state = S_TRAP;
            // Unused encodings are treated like an illegal instruction.
            default:  nxt_state = S_TRAP;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs. While reset is held every output is forced to
    // 0, even though the state register already reads FETCH.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_code   = ALU_ADD;
        illegal    = 1'b0;
        if (!rst_n) begin
            alu_code = 4'b0000;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    // IR and PC load only on the cycle the fetch completes.
                    ir_write  = ready_eff;
                    pc_write  = ready_eff;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_code  = funct_to_alu(funct);
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_code  = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_write  = is_bne ? ~zero : zero;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_I_WB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign alu_control = ALU_CTRL_W'(alu_code);
    assign state       = cur_state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit that drives the shared-memory datapath. A registered state machine sequences each instruction through fetch, decode, execute, memory and writeback, and produces all datapath strobes and the ALU control code. It supports R-type AND/OR/ADD/SUB/SLT, lw, sw, beq, bne, addi and j, and stalls on a memory ready handshake. It also traps on illegal encodings and counts retired instructions.

## Interface
- ALU_CTRL_W, 4: alu_control width; must be ≥4; bits above [3:0] are driven 0.
- MEM_WAIT_EN, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, memory states last exactly 1 cycle.
- CNT_W, 32: width of instr_count.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; the datapath holds it stable from DECODE until the next FETCH completes.
- funct  in  6  IR[5:0]; same stability rule as opcode.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory has completed the current access.
- pc_write  out  1  load PC.
- pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath strobes.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_control  out  ALU_CTRL_W  0000 = AND, 0001 = OR, 0010 = ADD, 0110 = SUB, 0111 = SLT.
- state  out  4  current state encoding, for debug.
- illegal  out  1  high while in TRAP.
- instr_count  out  CNT_W  number of retired instructions.

## Operation
- All outputs are Moore outputs, decoded from the state register. Exceptions: ir_write and pc_write in FETCH are gated by mem_ready; pc_write in BRANCH depends on zero.
- Unlisted strobes are 0 in every state. alu_control defaults to ADD.
- State encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, R_EXEC = 6, R_WB = 7, BRANCH = 8, I_EXEC = 9, I_WB = 10, JUMP = 11, TRAP = 12.
- FETCH: mem_read = 1, alu_src_b = 01, ADD, pc_src = 00.
  - ir_write = pc_write = mem_ready (forced 1 when MEM_WAIT_EN = 0).
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_b = 11, ADD. Next state by opcode:
  - 000000 → R_EXEC.
  - 100011 (lw) or 101011 (sw) → MEM_ADDR.
  - 000100 (beq) or 000101 (bne) → BRANCH.
  - 001000 (addi) → I_EXEC.
  - 000010 (j) → JUMP.
  - Any other opcode, or R-type with a funct outside {100100, 100101, 100000, 100010, 101010} → TRAP.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ADD. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: mem_read = 1, i_or_d = 1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retire, go to FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1. Wait for mem_ready, then retire and go to FETCH.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_control from funct (AND/OR/ADD/SUB/SLT). Go to R_WB.
- R_WB: reg_write = 1, reg_dst = 1. Retire, go to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, SUB, pc_src = 01.
  - pc_write = zero for beq, ~zero for bne.
  - Retire, go to FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 10, ADD. Go to I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retire, go to FETCH.
- JUMP: pc_src = 10, pc_write = 1. Retire, go to FETCH.
- TRAP: illegal = 1 and every write/read strobe 0. TRAP is absorbing; only reset leaves it.
- Retire: instr_count increments by 1 on the edge leaving a retiring state. It wraps modulo 2^CNT_W and never saturates. TRAP does not count.

## Timing
- rst_n low, at any time including mid-instruction or mid-wait: state = FETCH and instr_count = 0 immediately (asynchronously). While rst_n is low, every output is 0, including mem_read, pc_write and illegal.
- The first FETCH is active on the first rising edge after rst_n is deasserted.
- Zero-wait cycles per instruction:
  - R-type: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne: 3.
  - addi: 4.
  - j: 3.
- Each cycle that mem_ready is low in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle. Outputs hold steady during the wait.
- mem_ready asserted in any other state is ignored. Late assertion for a previous access has no effect.
- opcode/funct are sampled only in DECODE and R_EXEC. zero is sampled only in BRANCH.

## Test plan
- Reset: pulse rst_n low for 3 cycles in the middle of MEM_RD → all outputs 0 while low, then state = 0, instr_count = 0. The first cycle after release shows mem_read = 1.
- R-type sequence, mem_ready tied 1: add (funct 100000), then slt (funct 101010).
  - Required: states 0, 1, 6, 7 per instruction.
  - alu_control = 0010 for add and 0111 for slt in R_EXEC.
  - reg_dst = reg_write = 1 in R_WB.
  - instr_count = 2 after 8 cycles.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total. ir_write asserts only in the ready cycle. MEM_WB has mem_to_reg = 1.
- Branches: beq with zero = 1 → pc_write = 1, pc_src = 01. beq with zero = 0 → pc_write = 0. bne with zero = 0 → pc_write = 1. Each takes 3 cycles.
- Illegal encodings: opcode 111111 → TRAP at cycle 3, illegal = 1 held for 20 cycles, instr_count unchanged. R-type funct 000111 → same result. Reset then recovers to FETCH.
- Counter wrap with CNT_W = 3: execute 9 j instructions → instr_count reads 1. MEM_WAIT_EN = 0 with mem_ready held 0 → sw completes in 4 cycles.
